riscv_dmem_arbiter: RTL
=======================

Name: riscv_dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the word-indexed data memory (`RISCV_Memory`). It shares the memory between the CPU load/store port and the UART peripheral's buffer port. Each transaction is a fixed 3-state sequence: grant, access, respond. Requests are latched at grant, range/size-checked, driven onto the memory strobes for exactly one cycle, and answered with a one-cycle ack carrying registered read data.

Parameters:
MEM_DEPTH, 1032, number of memory entries; valid addresses are 0..MEM_DEPTH-1
ADDR_W, 32, width of all address ports

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
cpu_req  input  1  CPU request, level; held until cpu_ack
cpu_we  input  1  1 = store, 0 = load
cpu_size  input  2  00 byte, 01 half, 10 word, 11 illegal
cpu_unsigned  input  1  zero-extend loads when 1
cpu_addr  input  ADDR_W  entry index
cpu_wdata  input  32  store data
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  32  load result, valid when cpu_ack=1
cpu_err  output  1  valid with cpu_ack; 1 = request rejected
uart_req, uart_we, uart_size, uart_unsigned, uart_addr, uart_wdata  input  same widths  UART port, same semantics
uart_ack, uart_rdata, uart_err  output  1/32/1  UART port, same semantics
mem_write  output  1  to memory MemWrite
mem_read  output  1  to memory MemRead
mem_size  output  2  to memory Size
mem_unsigned  output  1  to memory UnsignedOp
mem_addr  output  ADDR_W  to memory Address
mem_wdata  output  32  to memory WriteData
mem_rdata  input  32  from memory ReadData (combinational)
busy  output  1  1 in ACCESS and DONE states

Behaviour:
- Reset (synchronous at the rising edge with rst=1):
  - State -> IDLE; last_grant -> UART, so the CPU wins the first tie.
  - All outputs are 0: both ack, err and rdata outputs, all mem_* outputs, and busy.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If any req=1 at the edge, pick a winner, latch its we/size/unsigned/addr/wdata and the owner id, then go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the requester not equal to last_grant wins (round-robin).
  - last_grant updates at grant.
- Request check at grant: err_latched = (addr >= MEM_DEPTH) OR (size == 2'b11).
- ACCESS (exactly 1 cycle):
  - If err_latched=0, drive the mem_* outputs from the latch, with mem_write = we and mem_read = ~we.
  - If err_latched=1, hold mem_write = mem_read = 0.
  - On loads, capture mem_rdata into the owner's rdata register at the end of the cycle.
  - A store commits in the memory at the ACCESS->DONE edge.
  - Next state is DONE.
- Outside ACCESS, all mem_* outputs are 0 (address and data zeroed too).
- DONE (1 cycle):
  - The owner's ack = 1 and err = err_latched.
  - rdata holds the load value; it is 0 for stores and errors.
  - The non-owner's ack stays 0.
  - Next state is IDLE.
  - req inputs are ignored in DONE.
- Latency: req sampled high in IDLE at edge k -> ack high during cycle k+2. Throughput is one transaction per 3 cycles.
- Back-to-back transactions:
  - A requester that keeps req=1 after its ack re-arbitrates in IDLE, i.e. it issues a new transaction.
  - With both requesters held high, grants alternate CPU, UART, CPU, ...
- rdata registers retain their value until the owner's next transaction completes. err is valid only with ack.
- Sizes are passed through unchanged. Extension and truncation are performed by the memory; the arbiter does no data shaping.
- A request field change after grant does not affect the in-flight transaction.
- Reset mid-operation:
  - A store in ACCESS at the reset edge still commits, because the memory has no reset.
  - A load result in flight is discarded and no ack is issued.
  - After reset, the first tie goes to the CPU.

Test Plan:
- Reset, then CPU store word: addr 5, data 0xDEADBEEF, then CPU load word at addr 5 -> ack 2 cycles after each req edge, rdata = 0xDEADBEEF, err = 0, mem_write high for exactly 1 cycle.
- Both req=1 from reset, held for 4 transactions -> grant order CPU, UART, CPU, UART; acks never overlap; busy low exactly one cycle between transactions.
- UART store byte: data 0x000000F0 at addr 10, then CPU load byte signed and unsigned at addr 10 -> rdata 0xFFFFFFF0 and 0x000000F0 respectively.
- CPU load at addr 1032 and UART request with size=11 -> ack with err=1, rdata = 0, mem_read/mem_write never asserted.
- Assert rst during ACCESS of a CPU store (addr 3, data 0x12345678) -> no cpu_ack, all outputs 0 next cycle, subsequent load of addr 3 returns 0x12345678.
- Change cpu_addr/cpu_wdata the cycle after grant -> memory is written with the originally latched values.

Source files
------------

// File: rtl/riscv_dmem_arbiter.sv
// ============================================================================
// Module  : riscv_dmem_arbiter
// Brief   : Round-robin CPU/UART arbiter sequencing grant/access/respond
//           transactions onto a shared word-indexed data memory.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_dmem_arbiter #(
  parameter int MEM_DEPTH = 1032,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [1:0]        uart_size,
  input  logic              uart_unsigned,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [31:0]       uart_wdata,
  output logic              uart_ack,
  output logic [31:0]       uart_rdata,
  output logic              uart_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [1:0]        mem_size,
  output logic              mem_unsigned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_UART = 1'b1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  state_t state, state_next;

  logic              last_grant;
  logic              owner;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic              lat_err;
  logic [31:0]       cpu_rdata_q;
  logic [31:0]       uart_rdata_q;

  logic              any_req;
  logic              grant_uart;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic              sel_unsigned;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;
  logic              access_ok;
  logic [31:0]       load_value;

  assign any_req = cpu_req | uart_req;
  // On a tie the port that did not win last time gets the grant.
  assign grant_uart = uart_req & (~cpu_req | (last_grant == OWN_CPU));

  always_comb begin
    sel_we       = grant_uart ? uart_we       : cpu_we;
    sel_size     = grant_uart ? uart_size     : cpu_size;
    sel_unsigned = grant_uart ? uart_unsigned : cpu_unsigned;
    sel_addr     = grant_uart ? uart_addr     : cpu_addr;
    sel_wdata    = grant_uart ? uart_wdata    : cpu_wdata;
    sel_err      = ({1'b0, sel_addr} >= DEPTH_EXT) | (sel_size == 2'b11);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign load_value = (~lat_we & ~lat_err) ? mem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= OWN_UART;
      owner        <= OWN_CPU;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= 32'd0;
      lat_err      <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      uart_rdata_q <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && any_req) begin
        owner        <= grant_uart;
        last_grant   <= grant_uart;
        lat_we       <= sel_we;
        lat_size     <= sel_size;
        lat_unsigned <= sel_unsigned;
        lat_addr     <= sel_addr;
        lat_wdata    <= sel_wdata;
        lat_err      <= sel_err;
      end
      // Stores and rejected requests leave the owner's result at zero.
      if (state == ACCESS) begin
        if (owner == OWN_UART) uart_rdata_q <= load_value;
        else                   cpu_rdata_q  <= load_value;
      end
    end
  end

  assign access_ok    = (state == ACCESS) & ~lat_err;
  assign mem_write    = access_ok & lat_we;
  assign mem_read     = access_ok & ~lat_we;
  assign mem_size     = access_ok ? lat_size  : 2'b00;
  assign mem_unsigned = access_ok & lat_unsigned;
  assign mem_addr     = access_ok ? lat_addr  : '0;
  assign mem_wdata    = access_ok ? lat_wdata : 32'd0;

  assign cpu_ack    = (state == DONE) & (owner == OWN_CPU);
  assign uart_ack   = (state == DONE) & (owner == OWN_UART);
  assign cpu_err    = cpu_ack & lat_err;
  assign uart_err   = uart_ack & lat_err;
  assign cpu_rdata  = cpu_rdata_q;
  assign uart_rdata = uart_rdata_q;
  assign busy       = (state != IDLE);

endmodule

`default_nettype wire
